// File: rtl/rmt_pkg.sv
// Shared RMT stage widths: container sizes, container count and the derived PHV layout.
package rmt_pkg;

  localparam int CONT_NUM       = 8;
  localparam int W_6B           = 48;
  localparam int W_4B           = 32;
  localparam int W_2B           = 16;
  localparam int REMAIN_LEN_DEF = 356;
  localparam int PHV_LEN_DEF    = CONT_NUM * (W_6B + W_4B + W_2B) + REMAIN_LEN_DEF;

  // The PHV must be exactly the three container groups followed by the tail.
  function automatic bit phv_layout_ok(int phv_len, int w6, int w4, int w2, int remain_len);
    return phv_len == CONT_NUM * (w6 + w4 + w2) + remain_len;
  endfunction

endpackage

// File: rtl/phv_remain_fifo.sv
// Synchronous FIFO holding the PHV metadata tail while the ALUs compute.
module phv_remain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 356
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/phv_merger.sv
// Rebuilds the full PHV from the 6B/4B/2B ALU results and the buffered metadata tail,
// emitting one PHV per complete set under valid/ready backpressure.
module phv_merger
  import rmt_pkg::*;
#(
  parameter int STAGE        = 0,
  parameter int PHV_LEN      = PHV_LEN_DEF,
  parameter int REMAIN_LEN   = REMAIN_LEN_DEF,
  parameter int width_6B     = W_6B,
  parameter int width_4B     = W_4B,
  parameter int width_2B     = W_2B,
  parameter int REMAIN_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CONT_NUM*width_6B-1:0] alu_out_6B,
  input  logic                         alu_out_6B_valid,
  input  logic [CONT_NUM*width_4B-1:0] alu_out_4B,
  input  logic                         alu_out_4B_valid,
  input  logic [CONT_NUM*width_2B-1:0] alu_out_2B,
  input  logic                         alu_out_2B_valid,
  input  logic [REMAIN_LEN-1:0]        phv_remain_in,
  input  logic                         phv_remain_valid,
  output logic [PHV_LEN-1:0]           phv_out,
  output logic                         phv_out_valid,
  input  logic                         phv_out_ready,
  output logic                         stall_upstream,
  output logic                         err_overflow,
  output logic [31:0]                  phv_out_cnt
);

  localparam int CW = $clog2(REMAIN_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(REMAIN_DEPTH - 1);
  localparam bit PARAMS_OK = phv_layout_ok(PHV_LEN, width_6B, width_4B, width_2B, REMAIN_LEN)
                             && (REMAIN_DEPTH >= 2) && ((REMAIN_DEPTH & (REMAIN_DEPTH - 1)) == 0)
                             && (STAGE >= 0);

  if (!PARAMS_OK) begin : g_bad_params
    $error("phv_merger: inconsistent PHV layout or tail FIFO depth");
  end

  logic [CONT_NUM*width_6B-1:0] cap_6B;
  logic [CONT_NUM*width_4B-1:0] cap_4B;
  logic [CONT_NUM*width_2B-1:0] cap_2B;
  logic have_6B, have_4B, have_2B;
  logic [CONT_NUM*width_6B-1:0] grp_6B;
  logic [CONT_NUM*width_4B-1:0] grp_4B;
  logic [CONT_NUM*width_2B-1:0] grp_2B;
  logic [REMAIN_LEN-1:0]        fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CW-1:0]                fifo_count;
  logic                         fire;
  logic                         drop_any;

  phv_remain_fifo #(
    .DEPTH (REMAIN_DEPTH),
    .WIDTH (REMAIN_LEN)
  ) u_remain_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (phv_remain_valid),
    .din   (phv_remain_in),
    .pop   (fire),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A group that arrives in the firing cycle is used straight from the input.
  assign grp_6B = have_6B ? cap_6B : alu_out_6B;
  assign grp_4B = have_4B ? cap_4B : alu_out_4B;
  assign grp_2B = have_2B ? cap_2B : alu_out_2B;

  assign fire = (have_6B | alu_out_6B_valid) & (have_4B | alu_out_4B_valid)
              & (have_2B | alu_out_2B_valid) & ~fifo_empty
              & (~phv_out_valid | phv_out_ready);

  assign drop_any = (alu_out_6B_valid & have_6B & ~fire)
                  | (alu_out_4B_valid & have_4B & ~fire)
                  | (alu_out_2B_valid & have_2B & ~fire)
                  | (phv_remain_valid & fifo_full & ~fire);

  // Latch a new result when the slot is free (no fire) or is being emptied (fire).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_6B <= 1'b0;
      have_4B <= 1'b0;
      have_2B <= 1'b0;
      cap_6B  <= '0;
      cap_4B  <= '0;
      cap_2B  <= '0;
    end else begin
      if (alu_out_6B_valid && (fire == have_6B)) cap_6B <= alu_out_6B;
      if (alu_out_4B_valid && (fire == have_4B)) cap_4B <= alu_out_4B;
      if (alu_out_2B_valid && (fire == have_2B)) cap_2B <= alu_out_2B;
      have_6B <= fire ? (have_6B & alu_out_6B_valid) : (have_6B | alu_out_6B_valid);
      have_4B <= fire ? (have_4B & alu_out_4B_valid) : (have_4B | alu_out_4B_valid);
      have_2B <= fire ? (have_2B & alu_out_2B_valid) : (have_2B | alu_out_2B_valid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
    end else if (fire) begin
      phv_out       <= {grp_6B, grp_4B, grp_2B, fifo_head};
      phv_out_valid <= 1'b1;
    end else if (phv_out_ready) begin
      phv_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_upstream <= 1'b0;
      err_overflow   <= 1'b0;
      phv_out_cnt    <= '0;
    end else begin
      stall_upstream <= (fifo_count >= STALL_LVL) || (phv_out_valid && !phv_out_ready);
      err_overflow   <= err_overflow | drop_any;
      if (phv_out_valid && phv_out_ready) phv_out_cnt <= phv_out_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_phv_merger.sv
// Directed and randomized checks of phv_merger against a queue-based transaction model.
module tb_phv_merger;
  import rmt_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = PHV_LEN_DEF;
  localparam int RW    = REMAIN_LEN_DEF;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [383:0]   alu_out_6B = '0;
  logic           alu_out_6B_valid = 1'b0;
  logic [255:0]   alu_out_4B = '0;
  logic           alu_out_4B_valid = 1'b0;
  logic [127:0]   alu_out_2B = '0;
  logic           alu_out_2B_valid = 1'b0;
  logic [RW-1:0]  phv_remain_in = '0;
  logic           phv_remain_valid = 1'b0;
  logic [PW-1:0]  phv_out;
  logic           phv_out_valid;
  logic           phv_out_ready = 1'b1;
  logic           stall_upstream;
  logic           err_overflow;
  logic [31:0]    phv_out_cnt;

  phv_merger #(.REMAIN_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_out_6B       (alu_out_6B),
    .alu_out_6B_valid (alu_out_6B_valid),
    .alu_out_4B       (alu_out_4B),
    .alu_out_4B_valid (alu_out_4B_valid),
    .alu_out_2B       (alu_out_2B),
    .alu_out_2B_valid (alu_out_2B_valid),
    .phv_remain_in    (phv_remain_in),
    .phv_remain_valid (phv_remain_valid),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .phv_out_ready    (phv_out_ready),
    .stall_upstream   (stall_upstream),
    .err_overflow     (err_overflow),
    .phv_out_cnt      (phv_out_cnt)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: one pending slot per group as a queue, tail FIFO as a queue.
  logic [383:0]  q6 [$];
  logic [255:0]  q4 [$];
  logic [127:0]  q2 [$];
  logic [RW-1:0] qt [$];
  logic [PW-1:0] m_out;
  logic          m_valid;
  logic          m_err;
  logic          m_stall;
  logic [31:0]   m_cnt;

  function automatic logic [383:0] rnd384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_compared++;
    assert (got === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (low 256 bits shown)", tag, got[255:0], exp[255:0]);
    end
  endtask

  task automatic modelReset();
    q6.delete(); q4.delete(); q2.delete(); qt.delete();
    m_out = '0; m_valid = 1'b0; m_err = 1'b0; m_stall = 1'b0; m_cnt = '0;
  endtask

  task automatic modelStep();
    logic fire;
    logic [383:0]  g6;
    logic [255:0]  g4;
    logic [127:0]  g2;
    logic [RW-1:0] gt;
    fire = (q6.size() > 0 || alu_out_6B_valid) && (q4.size() > 0 || alu_out_4B_valid)
        && (q2.size() > 0 || alu_out_2B_valid) && (qt.size() > 0)
        && (!m_valid || phv_out_ready);
    if (m_valid && phv_out_ready) m_cnt++;
    m_stall = (qt.size() >= DEPTH - 1) || (m_valid && !phv_out_ready);
    if (fire) begin
      if (q6.size() > 0) begin g6 = q6.pop_front(); if (alu_out_6B_valid) q6.push_back(alu_out_6B); end
      else g6 = alu_out_6B;
      if (q4.size() > 0) begin g4 = q4.pop_front(); if (alu_out_4B_valid) q4.push_back(alu_out_4B); end
      else g4 = alu_out_4B;
      if (q2.size() > 0) begin g2 = q2.pop_front(); if (alu_out_2B_valid) q2.push_back(alu_out_2B); end
      else g2 = alu_out_2B;
      gt = qt.pop_front();
      m_out = {g6, g4, g2, gt};
      m_valid = 1'b1;
    end else begin
      if (phv_out_ready) m_valid = 1'b0;
      if (alu_out_6B_valid) begin if (q6.size() > 0) m_err = 1'b1; else q6.push_back(alu_out_6B); end
      if (alu_out_4B_valid) begin if (q4.size() > 0) m_err = 1'b1; else q4.push_back(alu_out_4B); end
      if (alu_out_2B_valid) begin if (q2.size() > 0) m_err = 1'b1; else q2.push_back(alu_out_2B); end
    end
    if (phv_remain_valid) begin
      if (qt.size() < DEPTH) qt.push_back(phv_remain_in);
      else m_err = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("phv_out_valid", PW'(phv_out_valid), PW'(m_valid));
    checkOutput("phv_out", phv_out, m_out);
    checkOutput("err_overflow", PW'(err_overflow), PW'(m_err));
    checkOutput("phv_out_cnt", PW'(phv_out_cnt), PW'(m_cnt));
    checkOutput("stall_upstream", PW'(stall_upstream), PW'(m_stall));
  endtask

  task automatic applyStimulus(input logic v6, input logic v4, input logic v2, input logic vt,
                               input logic rdy, input logic [383:0] d6, input logic [255:0] d4,
                               input logic [127:0] d2, input logic [RW-1:0] dt);
    alu_out_6B_valid = v6; alu_out_6B = d6;
    alu_out_4B_valid = v4; alu_out_4B = d4;
    alu_out_2B_valid = v2; alu_out_2B = d2;
    phv_remain_valid = vt; phv_remain_in = dt;
    phv_out_ready    = rdy;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
    alu_out_6B_valid = 1'b0;
    alu_out_4B_valid = 1'b0;
    alu_out_2B_valid = 1'b0;
    phv_remain_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, rdy, '0, '0, '0, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("rst_valid", PW'(phv_out_valid), '0);
    checkOutput("rst_phv", phv_out, '0);
    checkOutput("rst_err", PW'(err_overflow), '0);
    checkOutput("rst_cnt", PW'(phv_out_cnt), '0);
    checkOutput("rst_stall", PW'(stall_upstream), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [383:0]  d6a, d6b;
  logic [255:0]  d4a;
  logic [127:0]  d2a;
  logic [RW-1:0] tr;
  logic [PW-1:0] exp_phv;

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] basic merge");
    applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(1));
    idle(1, 1);
    applyStimulus(1, 1, 1, 0, 1, {8{48'hAAAA_AAAA_AAAA}}, {8{32'h5555_5555}}, {8{16'h1234}}, '0);
    exp_phv = {{8{48'hAAAA_AAAA_AAAA}}, {8{32'h5555_5555}}, {8{16'h1234}}, RW'(1)};
    checkOutput("t1_phv", phv_out, exp_phv);
    checkOutput("t1_valid", PW'(phv_out_valid), PW'(1));
    idle(1, 1);
    checkOutput("t1_cnt", PW'(phv_out_cnt), PW'(1));

    $display("[TB] staggered groups");
    d6a = rnd384(); d4a = d6a[255:0] ^ 256'h1; d2a = d6a[383:256];
    applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(2));
    applyStimulus(1, 0, 0, 0, 1, d6a, '0, '0, '0);
    idle(1, 1);
    applyStimulus(0, 1, 0, 0, 1, '0, d4a, '0, '0);
    idle(1, 1);
    checkOutput("t2_wait", PW'(phv_out_valid), PW'(0));
    applyStimulus(0, 0, 1, 0, 1, '0, '0, d2a, '0);
    checkOutput("t2_valid", PW'(phv_out_valid), PW'(1));
    checkOutput("t2_6B", PW'(phv_out[PW-1 -: 384]), PW'(d6a));
    checkOutput("t2_4B", PW'(phv_out[PW-385 -: 256]), PW'(d4a));
    idle(1, 1);
    checkOutput("t2_cnt", PW'(phv_out_cnt), PW'(2));

    $display("[TB] backpressure");
    d6a = rnd384(); d6b = rnd384();
    applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(3));
    applyStimulus(1, 1, 1, 0, 0, d6a, d6a[255:0], d6a[127:0], '0);
    checkOutput("t3_first", PW'(phv_out[PW-1 -: 384]), PW'(d6a));
    applyStimulus(0, 0, 0, 1, 0, '0, '0, '0, RW'(4));
    applyStimulus(1, 1, 1, 0, 0, d6b, d6b[255:0], d6b[127:0], '0);
    idle(2, 0);
    checkOutput("t3_hold", PW'(phv_out[PW-1 -: 384]), PW'(d6a));
    checkOutput("t3_hold_valid", PW'(phv_out_valid), PW'(1));
    checkOutput("t3_stall", PW'(stall_upstream), PW'(1));
    idle(1, 1);
    checkOutput("t3_second", PW'(phv_out[PW-1 -: 384]), PW'(d6b));
    checkOutput("t3_b2b_valid", PW'(phv_out_valid), PW'(1));
    checkOutput("t3_no_err", PW'(err_overflow), PW'(0));
    idle(1, 1);

    $display("[TB] tail overflow");
    doReset();
    for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(k));
    checkOutput("t4_err", PW'(err_overflow), PW'(1));
    for (int k = 1; k <= 4; k++) begin
      d6a = rnd384();
      applyStimulus(1, 1, 1, 0, 1, d6a, d6a[383:128], d6a[383:256], '0);
      tr = phv_out[RW-1:0];
      checkOutput("t4_tail_order", PW'(tr), PW'(k));
    end
    applyStimulus(1, 1, 1, 0, 1, d6a, d6a[255:0], d6a[127:0], '0);
    checkOutput("t4_no_fifth", PW'(phv_out_valid), PW'(0));

    $display("[TB] group overflow");
    doReset();
    d6a = rnd384(); d6b = ~d6a;
    applyStimulus(1, 0, 0, 0, 1, d6a, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, 1, d6b, '0, '0, '0);
    checkOutput("t5_err", PW'(err_overflow), PW'(1));
    applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(9));
    idle(1, 1);
    applyStimulus(0, 1, 1, 0, 1, '0, d6b[255:0], d6b[127:0], '0);
    checkOutput("t5_kept_first", PW'(phv_out[PW-1 -: 384]), PW'(d6a));

    $display("[TB] reset mid-operation");
    doReset();
    d6a = rnd384();
    applyStimulus(1, 1, 0, 1, 1, d6a, d6a[255:0], '0, RW'(7));
    applyStimulus(0, 0, 0, 1, 1, '0, '0, '0, RW'(8));
    doReset();
    applyStimulus(1, 1, 1, 0, 1, d6a, d6a[255:0], d6a[127:0], '0);
    idle(3, 1);
    checkOutput("t6_no_output", PW'(phv_out_valid), PW'(0));
    checkOutput("t6_cnt", PW'(phv_out_cnt), PW'(0));

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 400; i++) begin
      d6a = rnd384(); d6b = rnd384();
      applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 70,
                    d6a, d6b[255:0], d6b[383:256], d6a[RW-1:0] ^ d6b[RW-1:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/phv_merger.md
Name: phv_merger

Overview:
- Reverse end of the stage's action crossbar: collects ALU results for the 6B, 4B and 2B container groups and rebuilds the full PHV for the next RMT stage.
- Buffers the untouched metadata/conditional tail (phv_remain) in a small FIFO to cover ALU latency.
- Joins the three groups with the oldest buffered tail and emits one PHV per match, under valid/ready backpressure.

Parameters:
- STAGE, 0, stage index; informational only.
- PHV_LEN, 1124, full PHV width; must equal 8*width_6B + 8*width_4B + 8*width_2B + REMAIN_LEN.
- REMAIN_LEN, 356, width of the metadata/conditional tail.
- width_6B, 48, 6B container width.
- width_4B, 32, 4B container width.
- width_2B, 16, 2B container width.
- REMAIN_DEPTH, 4, depth of the tail FIFO; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alu_out_6B  in  384  container i occupies [i*48 +: 48].
- alu_out_6B_valid  in  1  6B group result valid.
- alu_out_4B  in  256  container i occupies [i*32 +: 32].
- alu_out_4B_valid  in  1  4B group result valid.
- alu_out_2B  in  128  container i occupies [i*16 +: 16].
- alu_out_2B_valid  in  1  2B group result valid.
- phv_remain_in  in  REMAIN_LEN  tail issued alongside the ALU operands.
- phv_remain_valid  in  1  push strobe for the tail.
- phv_out  out  PHV_LEN  rebuilt PHV.
- phv_out_valid  out  1  output valid.
- phv_out_ready  in  1  downstream ready.
- stall_upstream  out  1  registered; high when FIFO count >= REMAIN_DEPTH-1, or when phv_out_valid=1 and phv_out_ready=0.
- err_overflow  out  1  sticky; set on any dropped input.
- phv_out_cnt  out  32  count of PHVs accepted downstream; wraps at 2^32.

Behaviour:
- Reset (async, rst=1): all outputs 0; FIFO empty with count 0; capture flags have_6B, have_4B, have_2B cleared. Reset mid-operation discards all partial data, and no PHV is emitted afterwards for it.
- Capture, per group g:
  - present_g = have_g | valid_g.
  - On valid_g with no fire, data is latched into cap_g and have_g is set.
  - If have_g=1 and valid_g=1 with no fire: the new data is dropped and err_overflow is set.
  - If have_g=1, valid_g=1 and fire in the same cycle: cap_g is consumed, the new data is latched, and have_g stays 1.
- Tail FIFO:
  - Push on phv_remain_valid; the entry is visible (non-empty) from the next cycle. There is no bypass.
  - Push while full: tail dropped, err_overflow set.
  - Simultaneous push and pop while full is legal; count is unchanged.
- Fire, evaluated combinationally in cycle N: all three present_g, AND FIFO non-empty, AND (phv_out_valid=0 OR phv_out_ready=1).
- On fire:
  - phv_out <= {grp6B, grp4B, grp2B, fifo_head}, where grp = cap_g when have_g=1, else the live input.
  - phv_out_valid <= 1 at N+1.
  - FIFO pops; consumed have_g flags clear unless refilled in the same cycle.
- Output handshake:
  - phv_out and phv_out_valid hold stable while valid=1 and ready=0.
  - Accept edge with no new fire clears valid.
  - Accept and fire in the same cycle give back-to-back output, valid stays 1; throughput is 1 PHV/cycle.
- phv_out_cnt increments on each valid&&ready.
- Latency: 1 cycle from the last-arriving group to phv_out_valid, provided its tail was pushed at least 1 cycle earlier. A tail pushed in the same cycle as all groups produces fire one cycle later.
- Groups present with FIFO empty: wait indefinitely; no error.
- FIFO non-empty with groups missing: wait indefinitely.
- err_overflow clears only on rst.

Decomposition:
- Shared package rmt_pkg holds the widths (width_6B/4B/2B, REMAIN_LEN, PHV_LEN) and the container count 8.
- Sub-module phv_remain_fifo: synchronous FIFO, REMAIN_DEPTH x REMAIN_LEN, with full/empty/count and async active-high reset.
- Capture flags, fire logic, output register and counters live in phv_merger.

Test Plan:
- Tail push 0x1 in cycle 0; all three groups valid in cycle 2 (6B all 0xAAAA..., 4B 0x5555..., 2B 0x1234...) -> cycle 3 phv_out = {those, tail 0x1}, valid=1; phv_out_cnt=1 after ready.
- Tail in cycle 0; 6B at cycle 1, 4B at cycle 3, 2B at cycle 5 -> single output at cycle 6, containing the captured 6B/4B values.
- Backpressure: phv_out_ready=0 for 4 cycles while a second full set arrives -> output holds first PHV stable; stall_upstream=1; second PHV follows the cycle after ready rises; no err_overflow.
- Push 5 tails with REMAIN_DEPTH=4 and no ALU data -> 5th tail dropped, err_overflow=1; then 4 group sets -> exactly 4 PHVs carrying tails 1..4 in order.
- 6B valid twice with no fire in between -> err_overflow=1; first 6B value is retained in the output.
- Assert rst for 1 cycle with two groups captured and 2 tails queued -> all outputs 0; a subsequent full set with no new tail produces no output.
